// File: rtl/vram_text_pkg.sv
// Shared types and geometry helpers for the text-mode raster and fetch engine.
package vram_text_pkg;

  localparam int CELL_PX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAM  = 2'd1,
    ROM  = 2'd2
  } fetch_state_t;

  function automatic int calc_aw(input int kb);
    return $clog2(kb * 1024);
  endfunction

  function automatic int active_w(input int hchars);
    return hchars * CELL_PX;
  endfunction

  function automatic int active_h(input int vrows);
    return vrows * CELL_PX;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Pixel/line counters with registered sync and blank decode; counters also exported
// so the fetch engine can schedule work against the raw position.
module raster_counter
  import vram_text_pkg::*;
#(
  parameter int HCHARS   = 40,
  parameter int VROWS    = 24,
  parameter int H_TOTAL  = 448,
  parameter int HS_START = 360,
  parameter int HS_W     = 32,
  parameter int V_TOTAL  = 312,
  parameter int VS_START = 240,
  parameter int VS_W     = 4,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_ce_pix,
  output logic [HW-1:0] o_hcount,
  output logic [VW-1:0] o_vcount,
  output logic          o_visible,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_hblank,
  output logic          o_vblank
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_LO = HW'(CELL_PX);
  localparam logic [HW-1:0] H_VIS_HI = HW'(active_w(HCHARS) + CELL_PX);
  localparam logic [HW-1:0] HS_LO    = HW'(HS_START);
  localparam logic [HW-1:0] HS_HI    = HW'(HS_START + HS_W);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_HI = VW'(active_h(VROWS));
  localparam logic [VW-1:0] VS_LO    = VW'(VS_START);
  localparam logic [VW-1:0] VS_HI    = VW'(VS_START + VS_W);

  logic [HW-1:0] r_hcount;
  logic [VW-1:0] r_vcount;
  logic          r_hsync, r_vsync, r_hblank, r_vblank;
  logic          w_hblank, w_vblank, w_hsync, w_vsync;

  // Active video starts one cell late to absorb the fetch pipeline.
  assign w_hblank = (r_hcount < H_VIS_LO) || (r_hcount >= H_VIS_HI);
  assign w_vblank = (r_vcount >= V_VIS_HI);
  assign w_hsync  = (r_hcount >= HS_LO) && (r_hcount < HS_HI);
  assign w_vsync  = (r_vcount >= VS_LO) && (r_vcount < VS_HI);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_hsync  <= 1'b0;
      r_vsync  <= 1'b0;
      r_hblank <= 1'b0;
      r_vblank <= 1'b0;
    end else if (i_ce_pix) begin
      r_hcount <= (r_hcount == H_LAST) ? '0 : r_hcount + HW'(1);
      if (r_hcount == H_LAST) begin
        r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + VW'(1);
      end
      r_hsync  <= w_hsync;
      r_vsync  <= w_vsync;
      r_hblank <= w_hblank;
      r_vblank <= w_vblank;
    end
  end

  assign o_hcount  = r_hcount;
  assign o_vcount  = r_vcount;
  assign o_visible = ~w_hblank & ~w_vblank;
  assign o_hsync   = r_hsync;
  assign o_vsync   = r_vsync;
  assign o_hblank  = r_hblank;
  assign o_vblank  = r_vblank;

endmodule

// File: rtl/vram_text_fetch.sv
// Text-mode generator: per cell fetches the character code from video RAM, the glyph
// row from the character ROM, and serialises it one cell later.
module vram_text_fetch
  import vram_text_pkg::*;
#(
  parameter int KB       = 2,
  parameter int HCHARS   = 40,
  parameter int VROWS    = 24,
  parameter int H_TOTAL  = 448,
  parameter int HS_START = 360,
  parameter int HS_W     = 32,
  parameter int V_TOTAL  = 312,
  parameter int VS_START = 240,
  parameter int VS_W     = 4,
  localparam int AW      = calc_aw(KB)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce_pix,
  output logic          ce1,
  output logic [AW-1:0] a1,
  input  logic [7:0]    q1,
  output logic [10:0]   cg_a,
  input  logic [7:0]    cg_q,
  output logic          pixel,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_FETCH_END = HW'(active_w(HCHARS));
  localparam logic [HW-1:0] H_LOAD_LO   = HW'(CELL_PX);
  localparam logic [VW-1:0] V_FETCH_END = VW'(active_h(VROWS));

  logic [HW-1:0] w_hcount;
  logic [VW-1:0] w_vcount;
  logic          w_visible, w_cell_start, w_fetch_trig, w_load;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_shift_nxt;

  fetch_state_t  r_state, w_state_nxt;
  logic [AW-1:0] r_a1;
  logic [2:0]    r_line;
  logic          r_cap;
  logic [7:0]    r_glyph, r_shift;
  logic          r_pixel;

  raster_counter #(
    .HCHARS(HCHARS), .VROWS(VROWS), .H_TOTAL(H_TOTAL), .HS_START(HS_START), .HS_W(HS_W),
    .V_TOTAL(V_TOTAL), .VS_START(VS_START), .VS_W(VS_W)
  ) u_raster (
    .clock     (clock),
    .reset     (reset),
    .i_ce_pix  (ce_pix),
    .o_hcount  (w_hcount),
    .o_vcount  (w_vcount),
    .o_visible (w_visible),
    .o_hsync   (hsync),
    .o_vsync   (vsync),
    .o_hblank  (hblank),
    .o_vblank  (vblank)
  );

  assign w_cell_start = (w_hcount[2:0] == 3'd0);
  assign w_fetch_trig = ce_pix && w_cell_start && (w_vcount < V_FETCH_END)
                        && (w_hcount < H_FETCH_END);
  assign w_load       = ce_pix && w_cell_start && (w_hcount >= H_LOAD_LO)
                        && (w_hcount <= H_FETCH_END);
  assign w_addr       = AW'(int'(w_vcount >> 3) * HCHARS + int'(w_hcount >> 3));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // A trigger outside IDLE is ignored; pixel spacing keeps it from happening.
  always_comb begin
    // NOTE: default first so no path through the case leaves the value held (no latch).
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_fetch_trig) w_state_nxt = RAM;
      RAM:     w_state_nxt = ROM;
      ROM:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The RAM holds q1 until the next ce1, so it serves as the code latch during ROM.
  always_comb begin
    ce1  = (r_state == RAM);
    cg_a = (r_state == ROM) ? {q1, r_line} : '0;
  end

  // Registered ROM data lands one clock after the ROM state is left.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a1    <= '0;
      r_line  <= '0;
      r_cap   <= 1'b0;
      r_glyph <= '0;
    end else begin
      if ((r_state == IDLE) && w_fetch_trig) begin
        r_a1   <= w_addr;
        r_line <= w_vcount[2:0];
      end
      r_cap <= (r_state == ROM);
      if (r_cap) r_glyph <= cg_q;
    end
  end

  assign w_shift_nxt = w_load ? r_glyph : {r_shift[6:0], 1'b0};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_pixel <= 1'b0;
    end else if (ce_pix) begin
      r_shift <= w_shift_nxt;
      r_pixel <= w_shift_nxt[7] & w_visible;
    end
  end

  assign a1    = r_a1;
  assign pixel = r_pixel;

endmodule

// File: tb/tb_vram_text_fetch.sv
// Directed bench for vram_text_fetch: a shortened frame (3 text rows) with RAM/ROM models,
// a hand-computed checkpoint table, a fetch-bus monitor and a reset-mid-fetch sequence.
module tb_vram_text_fetch;
  import vram_text_pkg::*;

  localparam int HCHARS   = 40;
  localparam int VROWS    = 3;
  localparam int H_TOTAL  = 448;
  localparam int HS_START = 360;
  localparam int HS_W     = 32;
  localparam int V_TOTAL  = 30;
  localparam int VS_START = 26;
  localparam int VS_W     = 2;
  localparam int AW       = 11;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ce_pix = 1'b0;
  logic          ce1;
  logic [AW-1:0] a1;
  logic [7:0]    q1 = 8'h00;
  logic [10:0]   cg_a;
  logic [7:0]    cg_q = 8'h00;
  logic          pixel, hsync, vsync, hblank, vblank;

  logic [7:0] mem [2048];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         h;
    int         v;
    logic [4:0] exp;   // {pixel, hsync, vsync, hblank, vblank}
  } vec_t;
  vec_t vecs [$];

  vram_text_fetch #(
    .KB(2), .HCHARS(HCHARS), .VROWS(VROWS), .H_TOTAL(H_TOTAL), .HS_START(HS_START),
    .HS_W(HS_W), .V_TOTAL(V_TOTAL), .VS_START(VS_START), .VS_W(VS_W)
  ) dut (
    .clock(clock), .reset(reset), .ce_pix(ce_pix), .ce1(ce1), .a1(a1), .q1(q1),
    .cg_a(cg_a), .cg_q(cg_q), .pixel(pixel), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] rom_byte(input logic [10:0] a);
    return (a == 11'h208) ? 8'hA5 : ~a[7:0];
  endfunction

  // Synchronous RAM read port and registered character ROM.
  always @(posedge clock) begin
    if (ce1) q1 <= mem[a1];
    cg_q <= rom_byte(cg_a);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_vid(input int h, input int v);
    logic hb, vb, hs, vs, px;
    logic [7:0] g;
    int col;
    hb = (h < 8) || (h >= HCHARS * 8 + 8);
    vb = (v >= VROWS * 8);
    hs = (h >= HS_START) && (h < HS_START + HS_W);
    vs = (v >= VS_START) && (v < VS_START + VS_W);
    px = 1'b0;
    if (!hb && !vb) begin
      col = (h - 8) / 8;
      g   = rom_byte({mem[((v / 8) * HCHARS + col) % 2048], 3'(v % 8)});
      px  = g[7 - ((h - 8) % 8)];
    end
    return {px, hs, vs, hb, vb};
  endfunction

  task automatic add_vec(input int h, input int v, input logic [4:0] e);
    vec_t t;
    t.h = h; t.v = v; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic tick_pix();
    @(negedge clock) ce_pix = 1'b1;
    @(negedge clock) ce_pix = 1'b0;
    @(negedge clock);
  endtask

  // Fetch-bus monitor: address order, single-clock ce1, and ROM address one clock later.
  logic mon_en = 1'b0;
  int   pulses = 0;
  initial begin
    logic prev_ce1;
    int   exp_a, pulse_line;
    prev_ce1 = 1'b0; exp_a = 0; pulse_line = 0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (prev_ce1) check("cg_a_after_ce1", cg_a, {mem[exp_a % 2048], 3'(pulse_line % 8)});
        if (ce1) begin
          pulse_line = pulses / HCHARS;
          exp_a      = (pulse_line / 8) * HCHARS + pulses % HCHARS;
          check("ce1_width", prev_ce1, 0);
          check($sformatf("a1_seq#%0d", pulses), a1, exp_a);
          pulses++;
        end
        prev_ce1 = ce1;
      end else begin
        prev_ce1 = 1'b0;
      end
    end
  end

  initial begin
    logic [4:0] got;
    logic [7:0] glyph0;
    int vi;
    glyph0 = 8'hA5;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
    mem[0] = 8'h41;

    add_vec(0, 0, 5'b00010);   add_vec(7, 0, 5'b00010);
    add_vec(8, 0, 5'b10000);   add_vec(9, 0, 5'b00000);
    add_vec(10, 0, 5'b10000);  add_vec(11, 0, 5'b00000);
    add_vec(12, 0, 5'b00000);  add_vec(13, 0, 5'b10000);
    add_vec(14, 0, 5'b00000);  add_vec(15, 0, 5'b10000);
    add_vec(16, 0, 5'b10000);  add_vec(20, 0, 5'b00000);
    add_vec(9, 8, 5'b00000);   add_vec(10, 8, 5'b10000);
    add_vec(320, 19, 5'b00000); add_vec(321, 19, 5'b10000);
    add_vec(325, 19, 5'b10000); add_vec(327, 19, 5'b00000);
    add_vec(328, 19, 5'b00010); add_vec(359, 19, 5'b00010);
    add_vec(360, 19, 5'b01010); add_vec(391, 19, 5'b01010);
    add_vec(392, 19, 5'b00010); add_vec(447, 19, 5'b00010);
    add_vec(0, 24, 5'b00011);  add_vec(100, 24, 5'b00001);
    add_vec(5, 26, 5'b00111);  add_vec(100, 27, 5'b00101);
    add_vec(100, 28, 5'b00001);

    // Reset held with pixel enables arriving every 4 clocks.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock) ce_pix = (i % 4 == 0);
    end
    ce_pix = 1'b0;
    check("rst_video", {pixel, hsync, vsync, hblank, vblank}, 0);
    check("rst_ce1", ce1, 0);
    check("rst_a1", a1, 0);
    check("rst_cg_a", cg_a, 0);
    check("rst_state", dut.r_state, IDLE);

    @(negedge clock) reset = 1'b1;
    mon_en = 1'b1;

    // Full shortened frame against the table and the pixel model.
    vi = 0;
    for (int v = 0; v < V_TOTAL; v++) begin
      for (int h = 0; h < H_TOTAL; h++) begin
        tick_pix();
        got = {pixel, hsync, vsync, hblank, vblank};
        check($sformatf("video h%0d v%0d", h, v), got, exp_vid(h, v));
        if (vi < vecs.size() && vecs[vi].h == h && vecs[vi].v == v) begin
          check($sformatf("vec%0d h%0d v%0d", vi, h, v), got, vecs[vi].exp);
          vi++;
        end
      end
    end
    check("vec_table_consumed", vi, vecs.size());
    mon_en = 1'b0;
    check("frame_ce1_pulses", pulses, VROWS * 8 * HCHARS);

    // Reset while the RAM read is in flight.
    @(negedge clock) ce_pix = 1'b1;
    @(negedge clock) ce_pix = 1'b0;
    check("mid_ce1_pre", ce1, 1);
    check("mid_a1_pre", a1, 0);
    reset = 1'b0;
    #1;
    check("mid_ce1_drop", ce1, 0);
    check("mid_state", dut.r_state, IDLE);
    check("mid_video", {pixel, hsync, vsync, hblank, vblank}, 0);
    check("mid_cg_a", cg_a, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock) ce_pix = (i % 4 == 0);
    end
    ce_pix = 1'b0;
    @(negedge clock) reset = 1'b1;

    @(negedge clock) ce_pix = 1'b1;
    @(negedge clock) ce_pix = 1'b0;
    check("rel_ce1", ce1, 1);
    check("rel_a1", a1, 0);
    @(negedge clock);
    check("rel_cg_a", cg_a, 11'h208);
    check("rel_ce1_low", ce1, 0);
    for (int h = 1; h < 16; h++) begin
      tick_pix();
      if (h >= 8) check($sformatf("rel_pixel h%0d", h), pixel, glyph0[15 - h]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
